// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver (7 data bits LSB first, even parity, 1 stop bit).
// Define RX_SERIAL_OVERRUN_EN to add the erro_overrun output.
module rx_serial_7e1 #(
    parameter int BAUD_DIV = 434,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       recebe,
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_frame,
`ifdef RX_SERIAL_OVERRUN_EN
    output logic       erro_overrun,
`endif
    output logic [3:0] db_estado
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP     = 4'd4,
        FIM      = 4'd5
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [6:0]  shift_q, shift_d;
    logic        par_bit_q, par_bit_d;
    logic        brk_q, brk_d;
    logic [6:0]  dados_q, dados_d;
    logic        erro_par_q, erro_par_d;
    logic        erro_frame_q, erro_frame_d;
    logic        tem_dado_q, tem_dado_d;
`ifdef RX_SERIAL_OVERRUN_EN
    logic        ovr_q, ovr_d;
`endif

    logic line_s;
    logic baud_done;
    logic half_done;
    logic frame_good;

    assign line_s     = sync2_q;
    assign baud_done  = (cnt_q == BAUD_LAST);
    assign half_done  = (cnt_q == HALF_LAST);
    assign frame_good = !erro_par_q && !erro_frame_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= INICIAL;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            brk_q        <= 1'b0;
            dados_q      <= '0;
            erro_par_q   <= 1'b0;
            erro_frame_q <= 1'b0;
            tem_dado_q   <= 1'b0;
`ifdef RX_SERIAL_OVERRUN_EN
            ovr_q        <= 1'b0;
`endif
        end else begin
            sync1_q      <= dado_serial;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            brk_q        <= brk_d;
            dados_q      <= dados_d;
            erro_par_q   <= erro_par_d;
            erro_frame_q <= erro_frame_d;
            tem_dado_q   <= tem_dado_d;
`ifdef RX_SERIAL_OVERRUN_EN
            ovr_q        <= ovr_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        brk_d        = brk_q;
        dados_d      = dados_q;
        erro_par_d   = erro_par_q;
        erro_frame_d = erro_frame_q;
        tem_dado_d   = tem_dado_q;
`ifdef RX_SERIAL_OVERRUN_EN
        ovr_d        = ovr_q;
`endif

        if (recebe) begin
            tem_dado_d = 1'b0;
`ifdef RX_SERIAL_OVERRUN_EN
            ovr_d      = 1'b0;
`endif
        end

        case (state_q)
            INICIAL: begin
                // After a break (stop bit low) the line must go idle before re-arming.
                if (brk_q) begin
                    if (line_s) brk_d = 1'b0;
                end else if (!line_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (half_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = line_s ? INICIAL : DADOS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DADOS: begin
                if (baud_done) begin
                    cnt_d     = '0;
                    shift_d   = {line_s, shift_q[6:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd6) state_d = PARIDADE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARIDADE: begin
                if (baud_done) begin
                    cnt_d     = '0;
                    par_bit_d = line_s;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                // Character and error flags become visible together with pronto.
                if (baud_done) begin
                    cnt_d        = '0;
                    dados_d      = shift_q;
                    erro_par_d   = (^shift_q) ^ par_bit_q;
                    erro_frame_d = !line_s;
                    brk_d        = !line_s;
                    state_d      = FIM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIM: begin
                state_d = INICIAL;
                if (frame_good) begin
`ifdef RX_SERIAL_OVERRUN_EN
                    if (tem_dado_q && !recebe) ovr_d = 1'b1;
`endif
                    tem_dado_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = INICIAL;
            end
        endcase
    end

    assign pronto        = (state_q == FIM);
    assign dados_ascii   = dados_q;
    assign tem_dado      = tem_dado_q;
    assign erro_paridade = erro_par_q;
    assign erro_frame    = erro_frame_q;
    assign db_estado     = state_q;
`ifdef RX_SERIAL_OVERRUN_EN
    assign erro_overrun  = ovr_q;
`endif

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Randomized and directed bench for rx_serial_7e1 against a frame-level reference model.
module tb_rx_serial_7e1;

    localparam int BAUD = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dado_serial = 1'b1;
    logic       recebe = 1'b0;
    logic [6:0] dados_ascii;
    logic       pronto, tem_dado, erro_paridade, erro_frame;
    logic [3:0] db_estado;
`ifdef RX_SERIAL_OVERRUN_EN
    logic       erro_overrun;
`endif

    rx_serial_7e1 #(.BAUD_DIV(BAUD), .HALF_DIV(BAUD / 2)) dut (
        .clock         (clock),
        .reset         (reset),
        .dado_serial   (dado_serial),
        .recebe        (recebe),
        .dados_ascii   (dados_ascii),
        .pronto        (pronto),
        .tem_dado      (tem_dado),
        .erro_paridade (erro_paridade),
        .erro_frame    (erro_frame),
`ifdef RX_SERIAL_OVERRUN_EN
        .erro_overrun  (erro_overrun),
`endif
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int pronto_cnt = 0;

    always @(negedge clock) if (pronto === 1'b1) pronto_cnt++;

    // Reference model: what the receiver should report after each whole frame.
    logic [6:0] m_dados = '0;
    logic       m_perr = 1'b0, m_ferr = 1'b0, m_tem = 1'b0, m_ovr = 1'b0;

    function automatic logic even_p(input logic [6:0] ch);
        return logic'($countones(ch) % 2);
    endfunction

    task automatic model_frame(input logic [6:0] ch, input logic p, input logic s, input logic rec);
        logic bad;
        bad     = (($countones(ch) + int'(p)) % 2 != 0) || !s;
        m_dados = ch;
        m_perr  = (($countones(ch) + int'(p)) % 2 != 0);
        m_ferr  = !s;
        if (!bad) begin
            m_ovr = rec ? 1'b0 : (m_ovr | m_tem);
            m_tem = 1'b1;
        end else if (rec) begin
            m_tem = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [6:0] ch, input logic p, input logic s);
        logic [9:0] bits;
        bits = {s, p, ch, 1'b0};
        for (int i = 0; i < 10; i++) begin
            dado_serial = bits[i];
            repeat (BAUD) @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_recebe();
        recebe = 1'b1;
        @(posedge clock); #1;
        recebe = 1'b0;
        m_tem = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic test_power_on();
        repeat (3) @(posedge clock); #1;
        vectors++;
        if ({dados_ascii, pronto, tem_dado, erro_paridade, erro_frame, db_estado} !== 15'd0) begin
            miscompares++;
            $display("FAIL power_on outputs got=%h want=0", {dados_ascii, pronto, tem_dado, erro_paridade, erro_frame, db_estado});
        end
        reset = 1'b1;
        repeat (5) @(posedge clock); #1;
    endtask

    task automatic test_char_a();
        int base;
        base = pronto_cnt;
        send_frame(7'h41, 1'b0, 1'b1);
        model_frame(7'h41, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clock); #1;
        vectors++;
        if (pronto_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL char_a pronto_count got=%0d want=1", pronto_cnt - base);
        end
        vectors++;
        if ({dados_ascii, erro_paridade, erro_frame, tem_dado} !== {m_dados, m_perr, m_ferr, m_tem}) begin
            miscompares++;
            $display("FAIL char_a flags got=%h want=%h", {dados_ascii, erro_paridade, erro_frame, tem_dado}, {m_dados, m_perr, m_ferr, m_tem});
        end
        pulse_recebe();
        vectors++;
        if (tem_dado !== 1'b0) begin
            miscompares++;
            $display("FAIL char_a recebe_clear tem_dado got=%b want=0", tem_dado);
        end
    endtask

    task automatic test_reset();
        int base;
        dado_serial = 1'b0;
        repeat (20) @(posedge clock); #1;
        vectors++;
        if (db_estado !== 4'd2) begin
            miscompares++;
            $display("FAIL reset mid_frame_state got=%0d want=2", db_estado);
        end
        reset = 1'b0;
        #1;
        m_dados = '0; m_perr = 1'b0; m_ferr = 1'b0; m_tem = 1'b0; m_ovr = 1'b0;
        vectors++;
        if ({dados_ascii, pronto, tem_dado, erro_paridade, erro_frame, db_estado} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset outputs got=%h want=0", {dados_ascii, pronto, tem_dado, erro_paridade, erro_frame, db_estado});
        end
        dado_serial = 1'b1;
        repeat (3) @(posedge clock); #1;
        reset = 1'b1;
        base = pronto_cnt;
        repeat (200) @(posedge clock); #1;
        vectors++;
        if (pronto_cnt - base !== 0 || db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL reset idle got pronto=%0d state=%0d want pronto=0 state=0", pronto_cnt - base, db_estado);
        end
    endtask

    task automatic test_parity_error();
        send_frame(7'h37, 1'b0, 1'b1);
        model_frame(7'h37, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clock); #1;
        vectors++;
        if ({dados_ascii, erro_paridade, erro_frame, tem_dado} !== {m_dados, m_perr, m_ferr, m_tem}) begin
            miscompares++;
            $display("FAIL parity flags got=%h want=%h", {dados_ascii, erro_paridade, erro_frame, tem_dado}, {m_dados, m_perr, m_ferr, m_tem});
        end
    endtask

    task automatic test_glitch();
        int base;
        base = pronto_cnt;
        dado_serial = 1'b0;
        repeat (2) @(posedge clock); #1;
        dado_serial = 1'b1;
        repeat (20) @(posedge clock); #1;
        vectors++;
        if (pronto_cnt - base !== 0 || db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL glitch got pronto=%0d state=%0d want pronto=0 state=0", pronto_cnt - base, db_estado);
        end
        vectors++;
        if ({dados_ascii, erro_paridade, erro_frame, tem_dado} !== {m_dados, m_perr, m_ferr, m_tem}) begin
            miscompares++;
            $display("FAIL glitch flags got=%h want=%h", {dados_ascii, erro_paridade, erro_frame, tem_dado}, {m_dados, m_perr, m_ferr, m_tem});
        end
    endtask

    task automatic test_framing();
        int base;
        base = pronto_cnt;
        send_frame(7'h41, 1'b0, 1'b0);
        model_frame(7'h41, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clock); #1;
        vectors++;
        if (pronto_cnt - base !== 1 || db_estado !== 4'd0) begin
            miscompares++;
            $display("FAIL framing break got pronto=%0d state=%0d want pronto=1 state=0", pronto_cnt - base, db_estado);
        end
        vectors++;
        if ({dados_ascii, erro_paridade, erro_frame, tem_dado} !== {m_dados, m_perr, m_ferr, m_tem}) begin
            miscompares++;
            $display("FAIL framing flags got=%h want=%h", {dados_ascii, erro_paridade, erro_frame, tem_dado}, {m_dados, m_perr, m_ferr, m_tem});
        end
        dado_serial = 1'b1;
        repeat (5) @(posedge clock); #1;
        base = pronto_cnt;
        send_frame(7'h30, 1'b0, 1'b1);
        model_frame(7'h30, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clock); #1;
        vectors++;
        if (pronto_cnt - base !== 1 ||
            {dados_ascii, erro_paridade, erro_frame, tem_dado} !== {m_dados, m_perr, m_ferr, m_tem}) begin
            miscompares++;
            $display("FAIL framing recover got pronto=%0d flags=%h want pronto=1 flags=%h", pronto_cnt - base,
                     {dados_ascii, erro_paridade, erro_frame, tem_dado}, {m_dados, m_perr, m_ferr, m_tem});
        end
        pulse_recebe();
    endtask

    task automatic test_back_to_back();
        int base;
        base = pronto_cnt;
        send_frame(7'h31, 1'b1, 1'b1);
        model_frame(7'h31, 1'b1, 1'b1, 1'b0);
        send_frame(7'h32, 1'b1, 1'b1);
        model_frame(7'h32, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clock); #1;
        vectors++;
        if (pronto_cnt - base !== 2 ||
            {dados_ascii, erro_paridade, erro_frame, tem_dado} !== {m_dados, m_perr, m_ferr, m_tem}) begin
            miscompares++;
            $display("FAIL back_to_back got pronto=%0d flags=%h want pronto=2 flags=%h", pronto_cnt - base,
                     {dados_ascii, erro_paridade, erro_frame, tem_dado}, {m_dados, m_perr, m_ferr, m_tem});
        end
`ifdef RX_SERIAL_OVERRUN_EN
        vectors++;
        if (erro_overrun !== m_ovr) begin
            miscompares++;
            $display("FAIL back_to_back overrun got=%b want=%b", erro_overrun, m_ovr);
        end
`endif
        pulse_recebe();
        // Acknowledge lands exactly in the completion cycle; the new character must win.
        fork
            send_frame(7'h41, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clock); #1;
                    if (pronto === 1'b1) break;
                end
                vectors++;
                if (pronto !== 1'b1) begin
                    miscompares++;
                    $display("FAIL recebe_in_fim pronto_timeout got=%b want=1", pronto);
                end
                recebe = 1'b1;
                @(posedge clock); #1;
                recebe = 1'b0;
            end
        join
        model_frame(7'h41, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clock); #1;
        vectors++;
        if (tem_dado !== m_tem) begin
            miscompares++;
            $display("FAIL recebe_in_fim tem_dado got=%b want=%b", tem_dado, m_tem);
        end
`ifdef RX_SERIAL_OVERRUN_EN
        vectors++;
        if (erro_overrun !== m_ovr) begin
            miscompares++;
            $display("FAIL recebe_in_fim overrun got=%b want=%b", erro_overrun, m_ovr);
        end
`endif
    endtask

    task automatic test_random();
        int base;
        logic [6:0] ch;
        logic p, s;
        for (int n = 0; n < 16; n++) begin
            ch = 7'($urandom_range(0, 127));
            p  = even_p(ch) ^ ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 5) != 0);
            base = pronto_cnt;
            send_frame(ch, p, s);
            model_frame(ch, p, s, 1'b0);
            if (!s) repeat ($urandom_range(0, 10)) @(posedge clock);
            #1;
            dado_serial = 1'b1;
            repeat (3 + $urandom_range(0, 4)) @(posedge clock); #1;
            vectors++;
            if (pronto_cnt - base !== 1 ||
                {dados_ascii, erro_paridade, erro_frame, tem_dado} !== {m_dados, m_perr, m_ferr, m_tem}) begin
                miscompares++;
                $display("FAIL random[%0d] ch=%h p=%b s=%b got pronto=%0d flags=%h want pronto=1 flags=%h", n, ch, p, s,
                         pronto_cnt - base, {dados_ascii, erro_paridade, erro_frame, tem_dado}, {m_dados, m_perr, m_ferr, m_tem});
            end
`ifdef RX_SERIAL_OVERRUN_EN
            vectors++;
            if (erro_overrun !== m_ovr) begin
                miscompares++;
                $display("FAIL random[%0d] overrun got=%b want=%b", n, erro_overrun, m_ovr);
            end
`endif
            if ($urandom_range(0, 1) == 1) pulse_recebe();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_power_on();
        test_char_a();
        test_reset();
        test_parity_error();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
